// File: rtl/i2c_slave_wr_rx_pkg.sv
// i2c_pkg: shared state encoding and widths for the write-only I2C target.
package i2c_pkg;
    localparam int BIT_CNT_W = 3;
    localparam int ADDR_W    = 7;
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_e;
endpackage

// File: rtl/i2c_slave_wr_rx_if.sv
// i2c_slave_wr_rx_if: debounced bus pins, pull-low requests and received-byte stream.
interface i2c_slave_wr_rx_if;
    logic       sda_i;
    logic       scl_i;
    logic       sda_oe_o;
    logic       scl_oe_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       rx_start_o;
    logic       rx_stop_o;
    logic       rx_ovf_o;
    logic       busy_o;
    modport slave (
        input  sda_i, scl_i, rx_ready_i,
        output sda_oe_o, scl_oe_o, rx_data_o, rx_valid_o, rx_start_o, rx_stop_o, rx_ovf_o, busy_o
    );
    modport master (
        output sda_i, scl_i, rx_ready_i,
        input  sda_oe_o, scl_oe_o, rx_data_o, rx_valid_o, rx_start_o, rx_stop_o, rx_ovf_o, busy_o
    );
endinterface

// File: rtl/i2c_slave_wr_rx_cond_det.sv
// i2c_cond_det: one-sample history of SDA/SCL giving SCL edges and START/STOP conditions.
module i2c_cond_det (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic sda_i,
    input  logic scl_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic sda_q, sda_d, scl_q, scl_d;
    // Next value of the history registers is simply the current pin level.
    always_comb begin
        sda_d = sda_i;
        scl_d = scl_i;
    end
    // Idle bus is high, so history resets to 1 to avoid a phantom edge after reset.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sda_q <= 1'b1;
            scl_q <= 1'b1;
        end else begin
            sda_q <= sda_d;
            scl_q <= scl_d;
        end
    end
    assign scl_rise  = !scl_q & scl_i;
    assign scl_fall  = scl_q & !scl_i;
    assign start_det = scl_q & scl_i & sda_q & !sda_i;
    assign stop_det  = scl_q & scl_i & !sda_q & sda_i;
endmodule

// File: rtl/i2c_slave_wr_rx.sv
// i2c_slave_wr_rx: write-only I2C target; optional SCL stretching on a full buffer via I2C_CLK_STRETCH_EN.
import i2c_pkg::*;
module i2c_slave_wr_rx #(
    parameter logic [ADDR_W-1:0] I2C_ADDR = 7'h50
) (
    input  logic clk_i,
    input  logic resetn_i,
    i2c_slave_wr_rx_if.slave bus
);
    logic scl_rise, scl_fall, start_det, stop_det;
    state_e state_q, state_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d, shift_n, rx_data_q, rx_data_d;
    logic sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
    logic rx_valid_q, rx_valid_d, rx_start_q, rx_start_d, rx_stop_q, rx_stop_d;
    logic rx_ovf_q, rx_ovf_d, busy_q, busy_d;
    logic ack_pend_q, ack_pend_d, phase_q, phase_d;
    i2c_cond_det u_det (
        .clk_i     (clk_i),
        .resetn_i  (resetn_i),
        .sda_i     (bus.sda_i),
        .scl_i     (bus.scl_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );
    assign shift_n = {shift_q[6:0], bus.sda_i};
    // Bus FSM; phase_q marks the second SCL fall of an ACK slot (release point).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        sda_oe_d   = sda_oe_q;
        scl_oe_d   = scl_oe_q;
        ack_pend_d = ack_pend_q;
        phase_d    = phase_q;
        busy_d     = busy_q;
        rx_valid_d = rx_valid_q & !bus.rx_ready_i;
        rx_start_d = 1'b0;
        rx_stop_d  = 1'b0;
        rx_ovf_d   = 1'b0;
        if (start_det | stop_det) begin
            state_d   = start_det ? ADDR : IDLE;
            cnt_d     = '0;
            sda_oe_d  = 1'b0;
            scl_oe_d  = 1'b0;
            phase_d   = 1'b0;
            rx_stop_d = busy_q;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, DATA: if (scl_rise) begin
                    shift_d = shift_n;
                    cnt_d   = cnt_q + 1'b1;
                    phase_d = 1'b0;
                    if (cnt_q == '1 && state_q == ADDR) begin
                        if (shift_n[7:1] == I2C_ADDR && !shift_n[0]) begin
                            state_d    = ADDR_ACK;
                            rx_start_d = 1'b1;
                            busy_d     = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else if (cnt_q == '1) begin
                        state_d = DATA_ACK;
                        if (!rx_valid_q | bus.rx_ready_i) begin
                            rx_data_d  = shift_n;
                            rx_valid_d = 1'b1;
                            ack_pend_d = 1'b1;
                        end else begin
                            ack_pend_d = 1'b0;
`ifndef I2C_CLK_STRETCH_EN
                            rx_ovf_d   = 1'b1;
`endif
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    sda_oe_d = !phase_q;
                    phase_d  = !phase_q;
                    if (phase_q) state_d = DATA;
                end
                DATA_ACK: begin
`ifdef I2C_CLK_STRETCH_EN
                    if (scl_oe_q) begin
                        if (phase_q) begin
                            scl_oe_d = 1'b0;
                        end else if (rx_valid_q & bus.rx_ready_i) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            ack_pend_d = 1'b1;
                            sda_oe_d   = 1'b1;
                            phase_d    = 1'b1;
                        end
                    end else
`endif
                    if (scl_fall) begin
                        if (phase_q) begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = DATA;
                        end else begin
                            sda_oe_d = ack_pend_q;
                            phase_d  = 1'b1;
`ifdef I2C_CLK_STRETCH_EN
                            if (!ack_pend_q) begin
                                if (rx_valid_q & !bus.rx_ready_i) begin
                                    scl_oe_d = 1'b1;
                                    phase_d  = 1'b0;
                                end else begin
                                    rx_data_d  = shift_q;
                                    rx_valid_d = 1'b1;
                                    ack_pend_d = 1'b1;
                                    sda_oe_d   = 1'b1;
                                end
                            end
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end
    // State and output registers; reset releases both pins with no stop pulse.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_start_q <= 1'b0;
            rx_stop_q  <= 1'b0;
            rx_ovf_q   <= 1'b0;
            busy_q     <= 1'b0;
            ack_pend_q <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
            rx_valid_q <= rx_valid_d;
            rx_start_q <= rx_start_d;
            rx_stop_q  <= rx_stop_d;
            rx_ovf_q   <= rx_ovf_d;
            busy_q     <= busy_d;
            ack_pend_q <= ack_pend_d;
            phase_q    <= phase_d;
        end
    end
    assign bus.sda_oe_o   = sda_oe_q;
    assign bus.scl_oe_o   = scl_oe_q;
    assign bus.rx_data_o  = rx_data_q;
    assign bus.rx_valid_o = rx_valid_q;
    assign bus.rx_start_o = rx_start_q;
    assign bus.rx_stop_o  = rx_stop_q;
    assign bus.rx_ovf_o   = rx_ovf_q;
    assign bus.busy_o     = busy_q;
endmodule

// File: tb/tb_i2c_slave_wr_rx.sv
// tb_i2c_slave_wr_rx: directed I2C write sequences against i2c_slave_wr_rx (I2C_CLK_STRETCH_EN aware).
module tb_i2c_slave_wr_rx;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic sda_m = 1'b1;
    logic scl_m = 1'b1;
    logic auto_ready = 1'b0;
    int n_vec = 0, n_err = 0, n_stretch = 0;
    int n_start = 0, n_stop = 0, n_ovf = 0, n_drv = 0, n_hs = 0;
    logic [7:0] hs_data = 8'h00;
    int s_start, s_stop, s_ovf, s_drv, s_hs;
    logic ack, dummy;

    always #5 clk = ~clk;

    i2c_slave_wr_rx_if bus ();
    assign bus.sda_i = sda_m & ~bus.sda_oe_o;
    assign bus.scl_i = scl_m & ~bus.scl_oe_o;

    i2c_slave_wr_rx #(.I2C_ADDR(7'h50)) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .bus      (bus)
    );

    // Event counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.rx_start_o) n_start <= n_start + 1;
        if (bus.rx_stop_o)  n_stop  <= n_stop + 1;
        if (bus.rx_ovf_o)   n_ovf   <= n_ovf + 1;
        if (bus.sda_oe_o | bus.scl_oe_o) n_drv <= n_drv + 1;
        if (bus.rx_valid_o & bus.rx_ready_i) begin
            n_hs    <= n_hs + 1;
            hs_data <= bus.rx_data_o;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_bit(input logic b, output logic oe);
        sda_m = b;
        tick(4);
        for (int i = 0; i < 200 && bus.scl_oe_o; i++) begin
            if (auto_ready && i == 10) bus.rx_ready_i = 1'b1;
            tick();
            n_stretch++;
        end
        if (bus.scl_oe_o) chk("stretch_timeout", int'(bus.scl_oe_o), 0);
        scl_m = 1'b1;
        tick(2);
        oe = bus.sda_oe_o;
        tick(2);
        scl_m = 1'b0;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic a);
        logic t;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], t);
        clk_bit(1'b1, a);
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        tick(2);
        scl_m = 1'b1;
        tick(4);
        sda_m = 1'b0;
        tick(4);
        scl_m = 1'b0;
        tick(4);
    endtask

    task automatic stop_c();
        sda_m = 1'b0;
        tick(4);
        scl_m = 1'b1;
        tick(4);
        sda_m = 1'b1;
        tick(4);
    endtask

    task automatic snap();
        s_start = n_start; s_stop = n_stop; s_ovf = n_ovf; s_drv = n_drv; s_hs = n_hs;
    endtask

    initial begin
        bus.rx_ready_i = 1'b0;
        tick(3);
        chk("rst_sda_oe", int'(bus.sda_oe_o), 0);
        chk("rst_scl_oe", int'(bus.scl_oe_o), 0);
        chk("rst_valid", int'(bus.rx_valid_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_data", int'(bus.rx_data_o), 0);
        resetn = 1'b1;
        tick(3);

        // Matched write of 0x3C with consumer always ready.
        bus.rx_ready_i = 1'b1;
        snap();
        start_c();
        send_byte(8'hA0, ack);
        chk("t1_addr_ack", int'(ack), 1);
        chk("t1_start", n_start - s_start, 1);
        chk("t1_busy", int'(bus.busy_o), 1);
        send_byte(8'h3C, ack);
        chk("t1_data_ack", int'(ack), 1);
        chk("t1_hs_cnt", n_hs - s_hs, 1);
        chk("t1_hs_data", int'(hs_data), 8'h3C);
        stop_c();
        chk("t1_stop", n_stop - s_stop, 1);
        chk("t1_busy_end", int'(bus.busy_o), 0);
        chk("t1_valid_end", int'(bus.rx_valid_o), 0);

        // Address 0x51: block must stay silent.
        snap();
        start_c();
        send_byte(8'hA2, ack);
        chk("t2_addr_nack", int'(ack), 0);
        send_byte(8'h55, ack);
        chk("t2_data_nack", int'(ack), 0);
        stop_c();
        chk("t2_drv", n_drv - s_drv, 0);
        chk("t2_start", n_start - s_start, 0);
        chk("t2_stop", n_stop - s_stop, 0);
        chk("t2_hs", n_hs - s_hs, 0);

        // Read request to own address is NACKed.
        snap();
        start_c();
        send_byte(8'hA1, ack);
        chk("t3_read_nack", int'(ack), 0);
        chk("t3_start", n_start - s_start, 0);
        chk("t3_busy", int'(bus.busy_o), 0);
        stop_c();
        chk("t3_stop", n_stop - s_stop, 0);

        // Two bytes with the consumer stalled.
        bus.rx_ready_i = 1'b0;
        snap();
        start_c();
        send_byte(8'hA0, ack);
        chk("t4_addr_ack", int'(ack), 1);
        send_byte(8'h11, ack);
        chk("t4_b1_ack", int'(ack), 1);
        chk("t4_b1_valid", int'(bus.rx_valid_o), 1);
        chk("t4_b1_data", int'(bus.rx_data_o), 8'h11);
`ifdef I2C_CLK_STRETCH_EN
        n_stretch = 0;
        auto_ready = 1'b1;
        send_byte(8'h22, ack);
        auto_ready = 1'b0;
        chk("t4_b2_ack", int'(ack), 1);
        chk("t4_stretched", int'(n_stretch > 0), 1);
        chk("t4_ovf", n_ovf - s_ovf, 0);
        chk("t4_hs_cnt", n_hs - s_hs, 2);
        chk("t4_hs_data", int'(hs_data), 8'h22);
        stop_c();
        chk("t4_stop", n_stop - s_stop, 1);
`else
        send_byte(8'h22, ack);
        chk("t4_b2_nack", int'(ack), 0);
        chk("t4_ovf", n_ovf - s_ovf, 1);
        chk("t4_held_data", int'(bus.rx_data_o), 8'h11);
        chk("t4_scl_never", int'(bus.scl_oe_o), 0);
        stop_c();
        chk("t4_stop", n_stop - s_stop, 1);
        bus.rx_ready_i = 1'b1;
        tick(2);
        chk("t4_hs_cnt", n_hs - s_hs, 1);
        chk("t4_hs_data", int'(hs_data), 8'h11);
`endif
        chk("t4_valid_end", int'(bus.rx_valid_o), 0);

        // Repeated START mid-byte, then new matched transfer.
        bus.rx_ready_i = 1'b1;
        snap();
        start_c();
        send_byte(8'hA0, ack);
        chk("t5_addr_ack", int'(ack), 1);
        clk_bit(1'b1, dummy);
        clk_bit(1'b0, dummy);
        clk_bit(1'b1, dummy);
        start_c();
        chk("t5_rs_stop", n_stop - s_stop, 1);
        chk("t5_rs_busy", int'(bus.busy_o), 0);
        send_byte(8'hA0, ack);
        chk("t5_addr2_ack", int'(ack), 1);
        chk("t5_start", n_start - s_start, 2);
        send_byte(8'h7E, ack);
        chk("t5_data_ack", int'(ack), 1);
        chk("t5_hs_data", int'(hs_data), 8'h7E);
        chk("t5_busy", int'(bus.busy_o), 1);

        // Reset in the middle of a byte.
        snap();
        for (int i = 0; i < 4; i++) clk_bit(1'b0, dummy);
        resetn = 1'b0;
        #1;
        chk("t6_busy", int'(bus.busy_o), 0);
        chk("t6_sda_oe", int'(bus.sda_oe_o), 0);
        chk("t6_valid", int'(bus.rx_valid_o), 0);
        chk("t6_data", int'(bus.rx_data_o), 0);
        tick(3);
        chk("t6_no_stop", n_stop - s_stop, 0);
        resetn = 1'b1;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_slave_wr_rx.md
Name: i2c_slave_wr_rx

Overview:
- Write-only I2C target front-end placed directly downstream of the SDA/SCL debounce stage; it consumes the debounced sda_i/scl_i.
- Detects START, repeated START and STOP conditions, then shifts in the address byte and compares it with a fixed 7-bit address.
- ACKs matching write transfers and presents each received data byte on a valid/ready interface.
- Its open-drain pull-low requests (sda_oe_o/scl_oe_o) go to the pads and also loop back to the debouncer's force-low inputs.

Parameters:
- I2C_ADDR, 7'h50, 7-bit target address to match.

Ports:
- clk_i  input  1  system clock
- resetn_i  input  1  reset, asynchronous, active-low
- sda_i  input  1  debounced SDA
- scl_i  input  1  debounced SCL
- sda_oe_o  output  1  1 = pull SDA low (ACK)
- scl_oe_o  output  1  1 = pull SCL low (stretch; tied 0 unless feature enabled)
- rx_data_o  output  8  received data byte, MSB first on the wire
- rx_valid_o  output  1  rx_data_o holds an unconsumed byte
- rx_ready_i  input  1  consumer accepts the byte when rx_valid_o & rx_ready_i
- rx_start_o  output  1  1-cycle pulse: address matched with W bit
- rx_stop_o  output  1  1-cycle pulse: STOP (or repeated START) ends a matched transfer
- rx_ovf_o  output  1  1-cycle pulse: data byte dropped because the buffer was full
- busy_o  output  1  matched transfer in progress (from rx_start_o to end of transfer)

Behaviour:
- Reset values:
  - All outputs 0.
  - Previous-sample registers for SDA/SCL = 1.
  - State = IDLE, bit counter = 0, shift register = 0.
- Edge detection uses one registered copy of each of sda_i and scl_i.
  - SCL rise = !prev & cur. SCL fall = prev & !cur.
  - START = prev_scl & scl_i & prev_sda & !sda_i.
  - STOP = prev_scl & scl_i & !prev_sda & sda_i.
- START or STOP takes priority over every other event in every state:
  - START → ADDR, bit counter = 0, sda_oe_o released.
  - STOP → IDLE, sda_oe_o and scl_oe_o released.
  - If busy_o was 1, either event pulses rx_stop_o in that cycle and clears busy_o.
- Bits are sampled on SCL rise into the shift register (MSB first); the 3-bit counter increments and wraps 7→0.
- States:
  - IDLE: wait for START.
  - ADDR: on the 8th rise compare shift[7:1] with I2C_ADDR.
    - Match with shift[0]=0 → ADDR_ACK and pulse rx_start_o.
    - Otherwise (mismatch, or R/W=1 since reads are unsupported) → IGNORE.
  - ADDR_ACK:
    - On the next SCL fall, assert sda_oe_o.
    - On the following SCL fall, release sda_oe_o → DATA.
    - busy_o is set together with rx_start_o.
  - DATA: on the 8th rise:
    - If rx_valid_o=0 or it is being accepted in this cycle: load rx_data_o, set rx_valid_o, set ack_pending=1.
    - Else: drop the byte, pulse rx_ovf_o, set ack_pending=0.
    - Then → DATA_ACK.
  - DATA_ACK:
    - On the next SCL fall, sda_oe_o = ack_pending (a dropped byte is NACKed by leaving SDA released).
    - On the following SCL fall, release → DATA.
  - IGNORE: never drive any pin; leave only on START/STOP.
- rx_valid_o clears on the cycle where rx_valid_o & rx_ready_i, independent of bus activity.
- A master NACK is not relevant because the block is write-only.
- SDA changes while SCL is high in DATA are legal only as START/STOP conditions.
- Latencies:
  - rx_valid_o asserts one clk after the clk in which the 8th SCL rise is detected.
  - sda_oe_o asserts one clk after the SCL fall is detected.
- Reset asserted mid-transfer: immediate return to reset values with pins released; no rx_stop_o pulse.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- With the macro defined:
  - In DATA_ACK, if rx_valid_o is still 1 at the SCL fall, assert scl_oe_o and hold ACK/NACK decision.
  - When the byte is accepted, drive sda_oe_o=1 (ACK) and release scl_oe_o one clk later.
  - Overflow therefore cannot occur; rx_ovf_o stays 0.
  - START/STOP during a stretch releases both pins.
- Without the macro: scl_oe_o is constant 0 and overflow/NACK works as described in Behaviour.

Decomposition:
- Package i2c_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE);
  - the bit-count width constant (3);
  - the address width constant (7).
- One sub-module: i2c_cond_det, which registers SDA/SCL and outputs scl_rise, scl_fall, start_det and stop_det.

Test Plan:
- START, 0xA0 (addr 0x50, W), 0x3C, STOP; rx_ready_i=1 → rx_start_o pulses once, ACK on both 9th clocks, rx_data_o=0x3C with one valid handshake, rx_stop_o pulses, busy_o returns to 0.
- START, 0xA2 (addr 0x51), 0x55, STOP → no pin ever driven low by the block; no rx_* pulses.
- START, 0xA1 (addr 0x50, R) → NACK, IGNORE state, no rx_start_o.
- Write 0x11 then 0x22 with rx_ready_i=0, no stretch build:
  - 0x11 is held on rx_data_o and ACKed;
  - 0x22 is NACKed and rx_ovf_o pulses once;
  - rx_data_o stays 0x11.
- Same stimulus with I2C_CLK_STRETCH_EN:
  - scl_oe_o=1 after the 0x22 byte until rx_ready_i rises;
  - then 0x22 is delivered and ACKed, and rx_ovf_o stays 0.
- Repeated START mid-DATA, followed by 0xA0 0x7E → rx_stop_o pulse, then a new rx_start_o and byte 0x7E; resetn_i low mid-byte → all outputs 0 on the next edge.
